// File: rtl/cam_pkg.sv
// Shared types and constants for the camera sequencer: FSM states, fault codes
// and the config-table terminator.
package cam_pkg;

    localparam int TMR_W = 32;

    localparam logic [15:0] CFG_END = 16'hFFFF;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_SCCB_NACK = 2'b01;
    localparam logic [1:0] ERR_FRAME_TO  = 2'b10;
    localparam logic [1:0] ERR_ACK_TO    = 2'b11;

    typedef enum logic [3:0] {
        OFF,
        PWR_UP,
        RST_HOLD,
        SETTLE,
        CFG_REQ,
        CFG_WAIT,
        IDLE,
        CAPTURE,
        ERROR
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !(s inside {OFF, IDLE, ERROR});
    endfunction

endpackage

// File: rtl/cam_timer.sv
// Loadable down-counter shared by all sequencer waits. A load pulse in cycle t
// with value V raises expired_o in cycle t+V-1 (V >= 2), so the load cycle counts.
module cam_timer
    import cam_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic             armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load_i) begin
            cnt_q   <= load_val_i - TMR_W'(2);
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) armed_q <= 1'b0;
            else             cnt_q   <= cnt_q - TMR_W'(1);
        end
    end

    // A reload masks any stale expiry left over from the previous wait.
    assign expired_o = armed_q && (cnt_q == '0) && !load_i;

endmodule

// File: rtl/cam_sequencer.sv
// Camera power-up, SCCB register-init streaming and capture sequencing.
// All outputs come straight from flops; busy/ready/error are decoded from the next state.
module cam_sequencer
    import cam_pkg::*;
#(
    parameter int RST_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 30000,
    parameter int NUM_REGS      = 16,
    parameter int AW            = 4,
    parameter int MAX_RETRY     = 2,
    parameter int ACK_TIMEOUT   = 5000,
    parameter int FRAME_TIMEOUT = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          continuous,
    output logic [AW-1:0] cfg_addr,
    input  logic [15:0]   cfg_data,
    output logic          sccb_req,
    output logic [7:0]    sccb_addr,
    output logic [7:0]    sccb_data,
    input  logic          sccb_ack,
    input  logic          sccb_err,
    output logic          cam_pwdn,
    output logic          cam_reset,
    output logic          capture,
    input  logic          frame_done,
    output logic          busy,
    output logic          ready,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [15:0]   frame_count
);

    state_t           state_q, state_d;
    logic [AW:0]      cfg_idx_q;
    logic [7:0]       retry_q;
    logic             cont_q, stop_pend_q;
    logic             tmr_load_q, tmr_expired;
    logic [TMR_W-1:0] tmr_val_q;
    logic             sccb_req_q, cam_pwdn_q, cam_reset_q, capture_q;
    logic             busy_q, ready_q, error_q;
    logic [7:0]       sccb_addr_q, sccb_data_q;
    logic [1:0]       err_code_q;
    logic [15:0]      frame_count_q;
    logic             cfg_end, retry_out, frame_end;

    cam_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_q),
        .load_val_i (tmr_val_q),
        .expired_o  (tmr_expired)
    );

    // The index is one bit wider than cfg_addr so a full table is detectable.
    assign cfg_end   = (cfg_idx_q == (AW+1)'(NUM_REGS)) || (cfg_data == CFG_END);
    assign retry_out = retry_q >= 8'(MAX_RETRY);
    assign frame_end = frame_done && (!cont_q || stop_pend_q || stop);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            OFF:      if (start) state_d = PWR_UP;
            PWR_UP:   state_d = RST_HOLD;
            RST_HOLD: if (tmr_expired) state_d = SETTLE;
            SETTLE:   if (tmr_expired) state_d = CFG_REQ;
            CFG_REQ:  state_d = cfg_end ? IDLE : CFG_WAIT;
            CFG_WAIT: begin
                if (sccb_err)         state_d = retry_out ? ERROR : CFG_REQ;
                else if (sccb_ack)    state_d = CFG_REQ;
                else if (tmr_expired) state_d = ERROR;
            end
            IDLE:     if (start && !stop) state_d = CAPTURE;
            CAPTURE: begin
                if (frame_end)                       state_d = IDLE;
                else if (!frame_done && tmr_expired) state_d = ERROR;
            end
            ERROR:    if (start) state_d = PWR_UP;
            default:  state_d = OFF;
        endcase
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= OFF;
            cfg_idx_q     <= '0;
            retry_q       <= '0;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            tmr_load_q    <= 1'b0;
            tmr_val_q     <= '0;
            sccb_req_q    <= 1'b0;
            sccb_addr_q   <= '0;
            sccb_data_q   <= '0;
            cam_pwdn_q    <= 1'b1;
            cam_reset_q   <= 1'b0;
            capture_q     <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_count_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= is_busy(state_d);
            ready_q    <= (state_d == IDLE);
            error_q    <= (state_d == ERROR);
            sccb_req_q <= (state_d == CFG_WAIT);
            capture_q  <= (state_q == CAPTURE) && (state_d == CAPTURE);
            tmr_load_q <= (state_d != state_q) || ((state_q == CAPTURE) && frame_done);
            case (state_d)
                RST_HOLD: tmr_val_q <= TMR_W'(RST_CYCLES);
                SETTLE:   tmr_val_q <= TMR_W'(SETTLE_CYCLES);
                CFG_WAIT: tmr_val_q <= TMR_W'(ACK_TIMEOUT);
                default:  tmr_val_q <= TMR_W'(FRAME_TIMEOUT);
            endcase

            case (state_q)
                PWR_UP:   cam_pwdn_q <= 1'b0;
                RST_HOLD: if (tmr_expired) cam_reset_q <= 1'b1;
                SETTLE: begin
                    if (tmr_expired) begin
                        cfg_idx_q <= '0;
                        retry_q   <= '0;
                    end
                end
                CFG_REQ: begin
                    if (!cfg_end) begin
                        sccb_addr_q <= cfg_data[15:8];
                        sccb_data_q <= cfg_data[7:0];
                    end
                end
                CFG_WAIT: begin
                    if (sccb_err) begin
                        retry_q <= retry_q + 8'd1;
                        if (retry_out) err_code_q <= ERR_SCCB_NACK;
                    end else if (sccb_ack) begin
                        cfg_idx_q <= cfg_idx_q + (AW+1)'(1);
                        retry_q   <= '0;
                    end else if (tmr_expired) begin
                        err_code_q <= ERR_ACK_TO;
                    end
                end
                IDLE: begin
                    if (start && !stop) begin
                        cont_q      <= continuous;
                        stop_pend_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (stop) stop_pend_q <= 1'b1;
                    if (frame_done)       frame_count_q <= frame_count_q + 16'd1;
                    else if (tmr_expired) err_code_q    <= ERR_FRAME_TO;
                end
                ERROR: begin
                    if (start) begin
                        err_code_q  <= ERR_NONE;
                        cam_pwdn_q  <= 1'b1;
                        cam_reset_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_addr    = cfg_idx_q[AW-1:0];
    assign sccb_req    = sccb_req_q;
    assign sccb_addr   = sccb_addr_q;
    assign sccb_data   = sccb_data_q;
    assign cam_pwdn    = cam_pwdn_q;
    assign cam_reset   = cam_reset_q;
    assign capture     = capture_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_cam_sequencer.sv
// Scoreboard bench for cam_sequencer: the stimulus side pushes expected SCCB writes
// and frame counts, independent monitor/responder processes pop, compare and reply.
module tb_cam_sequencer;
    import cam_pkg::*;

    localparam int RST_C  = 8;
    localparam int SET_C  = 16;
    localparam int NREG   = 4;
    localparam int AWB    = 2;
    localparam int MAXR   = 2;
    localparam int ACK_TO = 20;
    localparam int FRM_TO = 100;

    localparam int W_READY    = 0;
    localparam int W_ERROR    = 1;
    localparam int W_PWDN_LOW = 2;
    localparam int W_REQ      = 3;
    localparam int W_RST_HIGH = 4;

    logic           clk, rst, start, stop, continuous, sccb_ack, sccb_err, frame_done;
    logic [AWB-1:0] cfg_addr;
    logic [15:0]    cfg_data;
    logic           sccb_req, cam_pwdn, cam_reset, capture, busy, ready, error;
    logic [7:0]     sccb_addr, sccb_data;
    logic [1:0]     err_code;
    logic [15:0]    frame_count;

    logic [15:0]    cfg_tab [NREG];
    assign cfg_data = cfg_tab[cfg_addr];

    cam_sequencer #(
        .RST_CYCLES    (RST_C),
        .SETTLE_CYCLES (SET_C),
        .NUM_REGS      (NREG),
        .AW            (AWB),
        .MAX_RETRY     (MAXR),
        .ACK_TIMEOUT   (ACK_TO),
        .FRAME_TIMEOUT (FRM_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .sccb_req    (sccb_req),
        .sccb_addr   (sccb_addr),
        .sccb_data   (sccb_data),
        .sccb_ack    (sccb_ack),
        .sccb_err    (sccb_err),
        .cam_pwdn    (cam_pwdn),
        .cam_reset   (cam_reset),
        .capture     (capture),
        .frame_done  (frame_done),
        .busy        (busy),
        .ready       (ready),
        .error       (error),
        .err_code    (err_code),
        .frame_count (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          req_seen = 0;
    int          fc_model = 0;
    bit          resp_silent = 1'b0;
    int          nack_left [NREG];
    int          nack_used [NREG];
    int          resp_idx;
    logic [23:0] sccb_exp_q [$];
    logic [15:0] fc_exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: which writes the sensor should see, in order.
    task automatic expect_config(input int nack_idx, input int nacks);
        int attempts;
        for (int i = 0; i < NREG; i++) begin
            if (cfg_tab[i] == CFG_END) return;
            attempts = 1;
            if (i == nack_idx) attempts = (nacks > MAXR) ? MAXR + 1 : nacks + 1;
            for (int r = 0; r < attempts; r++) sccb_exp_q.push_back({8'(i), cfg_tab[i]});
            if (i == nack_idx && nacks > MAXR) return;
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            W_READY:    return ready;
            W_ERROR:    return error;
            W_PWDN_LOW: return !cam_pwdn;
            W_REQ:      return sccb_req;
            default:    return cam_reset;
        endcase
    endfunction

    task automatic count_until(input int which, input int budget, output int n);
        n = 0;
        while (!sel(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_sig(input int which, input int budget, input string name);
        int n;
        count_until(which, budget, n);
        check(name, 32'(sel(which)), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sccb_exp_q.delete();
        fc_exp_q.delete();
        foreach (nack_left[i]) nack_left[i] = 0;
        resp_silent = 1'b0;
        fc_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic random_table();
        foreach (cfg_tab[i]) cfg_tab[i] = 16'($urandom_range(0, 16'hFFFE));
    endtask

    task automatic pulse_frame();
        fc_model = (fc_model + 1) % 65536;
        fc_exp_q.push_back(16'(fc_model));
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    // SCCB slave model: replies three cycles after each new request.
    initial begin
        sccb_ack = 1'b0;
        sccb_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                foreach (nack_used[i]) nack_used[i] = 0;
            end else if (sccb_req && !resp_silent) begin
                resp_idx = int'(cfg_addr);
                repeat (2) @(negedge clk);
                if (nack_used[resp_idx] < nack_left[resp_idx]) begin
                    nack_used[resp_idx]++;
                    sccb_err = 1'b1;
                end else begin
                    sccb_ack = 1'b1;
                end
                @(negedge clk);
                sccb_ack = 1'b0;
                sccb_err = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic [15:0] prev_fc;
        logic [23:0] e;
        logic [15:0] f;
        prev_req = 1'b0;
        prev_fc  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                prev_fc  = '0;
            end else begin
                if (sccb_req && !prev_req) begin
                    req_seen++;
                    if (sccb_exp_q.size() == 0) begin
                        check("sccb_unexpected_write", 32'({8'(cfg_addr), sccb_addr, sccb_data}), 32'hFFFF_FFFF);
                    end else begin
                        e = sccb_exp_q.pop_front();
                        check("sccb_write", 32'({8'(cfg_addr), sccb_addr, sccb_data}), 32'(e));
                    end
                end
                if (frame_count != prev_fc) begin
                    if (fc_exp_q.size() == 0) begin
                        check("frame_unexpected", 32'(frame_count), 32'h1_0000);
                    end else begin
                        f = fc_exp_q.pop_front();
                        check("frame_count", 32'(frame_count), 32'(f));
                    end
                end
                prev_req = sccb_req;
                prev_fc  = frame_count;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected the run to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, base;
        bit stop_same;
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; frame_done = 1'b0;
        random_table();
        do_reset();

        check("rst_cam_pwdn",  32'(cam_pwdn), 32'd1);
        check("rst_cam_reset", 32'(cam_reset), 32'd0);
        check("rst_capture",   32'(capture), 32'd0);
        check("rst_sccb",      32'({sccb_req, sccb_addr, sccb_data}), 32'd0);
        check("rst_cfg_addr",  32'(cfg_addr), 32'd0);
        check("rst_flags",     32'({busy, ready, error}), 32'd0);
        check("rst_err_code",  32'(err_code), 32'd0);
        check("rst_frames",    32'(frame_count), 32'd0);

        // Full power-up with four valid entries.
        expect_config(-1, 0);
        base = req_seen;
        pulse_start();
        check("pwrup_busy", 32'(busy), 32'd1);
        wait_sig(W_PWDN_LOW, 5, "pwdn_released");
        count_until(W_RST_HIGH, 50, n);
        check("cam_reset_low_cycles", 32'(n), 32'(RST_C));
        count_until(W_REQ, 100, n);
        check("settle_to_first_req", 32'(n), 32'(SET_C + 1));
        wait_sig(W_READY, 500, "cfg_done_ready");
        check("cfg_write_count", 32'(req_seen - base), 32'(NREG));
        check("cfg_queue_empty", 32'(sccb_exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Early terminator at entry 2.
        do_reset();
        random_table();
        cfg_tab[2] = CFG_END;
        expect_config(-1, 0);
        base = req_seen;
        pulse_start();
        wait_sig(W_READY, 500, "term_ready");
        check("term_write_count", 32'(req_seen - base), 32'd2);
        check("term_queue_empty", 32'(sccb_exp_q.size()), 32'd0);

        // Entry 1 NACKed until retries run out.
        do_reset();
        random_table();
        nack_left[1] = MAXR + 1;
        expect_config(1, MAXR + 1);
        base = req_seen;
        pulse_start();
        wait_sig(W_ERROR, 500, "nack_error");
        check("nack_err_code", 32'(err_code), 32'(ERR_SCCB_NACK));
        check("nack_write_count", 32'(req_seen - base), 32'(MAXR + 2));
        check("nack_idle_outputs", 32'({sccb_req, busy, ready}), 32'd0);
        check("nack_queue_empty", 32'(sccb_exp_q.size()), 32'd0);

        // Silent SCCB slave: ack timeout after a full re-init from ERROR.
        nack_left[1] = 0;
        resp_silent = 1'b1;
        sccb_exp_q.push_back({8'd0, cfg_tab[0]});
        pulse_start();
        count_until(W_REQ, 200, n);
        count_until(W_ERROR, 100, n);
        check("ack_timeout_cycles", 32'(n), 32'(ACK_TO));
        check("ack_timeout_code", 32'(err_code), 32'(ERR_ACK_TO));
        check("ack_timeout_req", 32'(sccb_req), 32'd0);
        resp_silent = 1'b0;
        check("ack_queue_empty", 32'(sccb_exp_q.size()), 32'd0);

        expect_config(-1, 0);
        pulse_start();
        check("reinit_outputs", 32'({cam_pwdn, cam_reset, error, busy}), 32'b1001);
        check("reinit_err_clear", 32'(err_code), 32'(ERR_NONE));
        wait_sig(W_READY, 500, "reinit_ready");

        // Single-shot capture, frame 50 cycles after start.
        continuous = 1'b0;
        pulse_start();
        check("single_entry_capture", 32'(capture), 32'd0);
        n = 0;
        repeat (49) begin
            @(negedge clk);
            if (!capture) n++;
        end
        check("single_capture_low_cycles", 32'(n), 32'd0);
        pulse_frame();
        check("single_after_frame", 32'({capture, ready}), 32'b01);

        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_frame_ignored", 32'(frame_count), 32'(fc_model));

        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        check("start_stop_stays_idle", 32'({ready, capture, busy}), 32'b100);

        // Continuous capture, stop between the 2nd and 3rd frame (or with it).
        stop_same = 1'($urandom_range(0, 1));
        continuous = 1'b1;
        pulse_start();
        continuous = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 60)) @(negedge clk);
            check("cont_capture_high", 32'(capture), 32'd1);
            if (k == 2 && stop_same) stop = 1'b1;
            pulse_frame();
            stop = 1'b0;
            check("cont_capture_after_frame", 32'(capture), (k < 2) ? 32'd1 : 32'd0);
            if (k == 1 && !stop_same) begin
                repeat (3) @(negedge clk);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                check("cont_stop_pending", 32'(capture), 32'd1);
            end
        end
        check("cont_ready", 32'(ready), 32'd1);
        check("cont_frames", 32'(frame_count), 32'(fc_model));

        // Frame timeout, then full re-init.
        pulse_start();
        count_until(W_ERROR, 300, n);
        check("frame_timeout_cycles", 32'(n), 32'(FRM_TO));
        check("frame_timeout_code", 32'(err_code), 32'(ERR_FRAME_TO));
        check("frame_timeout_capture", 32'(capture), 32'd0);
        expect_config(-1, 0);
        pulse_start();
        check("replay_err_clear", 32'({err_code, cam_pwdn}), 32'b001);
        wait_sig(W_PWDN_LOW, 5, "replay_pwdn_released");
        count_until(W_RST_HIGH, 50, n);
        check("replay_reset_low_cycles", 32'(n), 32'(RST_C));
        wait_sig(W_READY, 500, "replay_ready");
        check("replay_frames_kept", 32'(frame_count), 32'(fc_model));

        // Asynchronous reset in the middle of continuous capture.
        continuous = 1'b1;
        pulse_start();
        continuous = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_capture_before", 32'(capture), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({capture, sccb_req, cam_pwdn, cam_reset}), 32'b0010);
        check("midrst_frames", 32'(frame_count), 32'd0);
        do_reset();
        check("midrst_state", 32'({busy, ready, error}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
